// File: rtl/simplez_mem_arbiter_pkg.sv
// Shared Simplez constants: default bus widths, requester port ids, arbiter FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simplez_pkg;

    localparam int SIMPLEZ_ADDRW = 9;
    localparam int SIMPLEZ_DATAW = 12;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ACC  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;

    // The requester that is not p; used to rotate priority on ties.
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/simplez_mem_arbiter_if.sv
// Bundle of both requester ports, the memory port and the status outputs of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req is held by a requester until its one-cycle ack pulse.
interface simplez_mem_arbiter_if
    import simplez_pkg::*;
#(
    parameter int ADDRW = SIMPLEZ_ADDRW,
    parameter int DATAW = SIMPLEZ_DATAW
) ();

    logic             cpu_req;
    logic             cpu_we;
    logic [ADDRW-1:0] cpu_addr;
    logic [DATAW-1:0] cpu_wdata;
    logic             cpu_ack;
    logic [DATAW-1:0] cpu_rdata;

    logic             ld_req;
    logic             ld_we;
    logic [ADDRW-1:0] ld_addr;
    logic [DATAW-1:0] ld_wdata;
    logic             ld_ack;
    logic [DATAW-1:0] ld_rdata;
    logic             ld_lock;

    logic [ADDRW-1:0] mem_addr;
    logic             mem_wr;
    logic [DATAW-1:0] mem_wdata;
    logic [DATAW-1:0] mem_rdata;

    logic             owner;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output ld_ack, ld_rdata,
        output mem_addr, mem_wr, mem_wdata,
        input  mem_rdata,
        output owner
    );

    // Requester / memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  ld_ack, ld_rdata,
        input  mem_addr, mem_wr, mem_wdata,
        output mem_rdata,
        input  owner
    );

endinterface

// File: rtl/simplez_mem_arbiter_rr_arb2.sv
// Two-way grant decision between CPU (port 0) and loader (port 1).
// Latency: purely combinational.
// Backpressure: none; the caller only consults the grant while idle.
module rr_arb2
    import simplez_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       owner,
    input  logic       lock,
    output logic       gnt_vld,
    output logic       gnt_port
);

    // Single requester wins outright; ties go lock-holder, then fixed loader, then non-owner.
    always_comb begin
        gnt_vld  = |req;
        gnt_port = PORT_CPU;
        if (req == 2'b10) begin
            gnt_port = PORT_LD;
        end else if (req == 2'b11) begin
            if (lock && (owner == PORT_LD)) begin
                gnt_port = PORT_LD;
            end else if (FIXED_PRIO != 0) begin
                gnt_port = PORT_LD;
            end else begin
                gnt_port = other_port(owner);
            end
        end
    end

endmodule

// File: rtl/simplez_mem_arbiter.sv
// Shares the single-port Simplez main memory between the CPU and the loader, one access at a time.
// Latency: request seen idle in cycle N -> memory access in N+1 -> ack pulse in N+2 -> idle in N+3.
// Backpressure: a requester holds req until its ack; the losing port simply waits in req.
module simplez_mem_arbiter
    import simplez_pkg::*;
#(
    parameter int ADDRW      = SIMPLEZ_ADDRW,
    parameter int DATAW      = SIMPLEZ_DATAW,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    simplez_mem_arbiter_if.slave  bus
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             owner_q;
    logic             we_q;
    logic [ADDRW-1:0] addr_q;
    logic [DATAW-1:0] wdata_q;
    logic             gnt_vld;
    logic             gnt_port;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .req      ({bus.ld_req, bus.cpu_req}),
        .owner    (owner_q),
        .lock     (bus.ld_lock),
        .gnt_vld  (gnt_vld),
        .gnt_port (gnt_port)
    );

    // FSM state register; the whole memory subsystem runs on the falling edge like the CPU core.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winner and its request fields at grant so later req changes cannot disturb the access.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= PORT_LD;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if ((state_q == ARB_IDLE) && gnt_vld) begin
            owner_q <= gnt_port;
            if (gnt_port == PORT_LD) begin
                we_q    <= bus.ld_we;
                addr_q  <= bus.ld_addr;
                wdata_q <= bus.ld_wdata;
            end else begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
            end
        end
    end

    // Next state plus memory and ack outputs; memory bus parks at all-ones address when not accessing.
    always_comb begin
        state_d       = state_q;
        bus.mem_addr  = '1;
        bus.mem_wr    = 1'b0;
        bus.mem_wdata = '0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_rdata = '0;
        bus.ld_ack    = 1'b0;
        bus.ld_rdata  = '0;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_vld) begin
                    state_d = ARB_ACC;
                end
            end
            ARB_ACC: begin
                state_d       = ARB_RSP;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                // rst gates the strobe directly so an abandoned write never reaches memory.
                bus.mem_wr    = we_q & ~rst;
            end
            ARB_RSP: begin
                state_d = ARB_IDLE;
                if (owner_q == PORT_LD) begin
                    bus.ld_ack   = 1'b1;
                    bus.ld_rdata = bus.mem_rdata;
                end else begin
                    bus.cpu_ack   = 1'b1;
                    bus.cpu_rdata = bus.mem_rdata;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign bus.owner = owner_q;

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Bench for simplez_mem_arbiter: round-robin and fixed-priority instances driven with identical stimulus.
// Latency: n/a.
// Backpressure: requesters hold req until ack, as a real CPU/loader would.
module tb_simplez_mem_arbiter;
    import simplez_pkg::*;

    localparam int AW = 9;
    localparam int DW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cpu_req, cpu_we, ld_req, ld_we, ld_lock;
    logic [AW-1:0] cpu_addr, ld_addr;
    logic [DW-1:0] cpu_wdata, ld_wdata;
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_dat;

    logic [1:0]         o_cpu_ack, o_ld_ack, o_mem_wr, o_owner;
    logic [1:0][DW-1:0] o_cpu_rdata, o_ld_rdata, o_mem_wdata, mem_rdata_arr;
    logic [1:0][AW-1:0] o_mem_addr;

    logic [DW-1:0] mem [2][512];
    bit            mem_init_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0 is round-robin, instance 1 gives the loader fixed priority on ties.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        simplez_mem_arbiter_if #(.ADDRW(AW), .DATAW(DW)) bus ();
        assign bus.cpu_req   = cpu_req;
        assign bus.cpu_we    = cpu_we;
        assign bus.cpu_addr  = cpu_addr;
        assign bus.cpu_wdata = cpu_wdata;
        assign bus.ld_req    = ld_req;
        assign bus.ld_we     = ld_we;
        assign bus.ld_addr   = ld_addr;
        assign bus.ld_wdata  = ld_wdata;
        assign bus.ld_lock   = ld_lock;
        assign bus.mem_rdata = mem_rdata_arr[g];
        assign o_cpu_ack[g]   = bus.cpu_ack;
        assign o_cpu_rdata[g] = bus.cpu_rdata;
        assign o_ld_ack[g]    = bus.ld_ack;
        assign o_ld_rdata[g]  = bus.ld_rdata;
        assign o_mem_addr[g]  = bus.mem_addr;
        assign o_mem_wr[g]    = bus.mem_wr;
        assign o_mem_wdata[g] = bus.mem_wdata;
        assign o_owner[g]     = bus.owner;

        simplez_mem_arbiter #(
            .ADDRW      (AW),
            .DATAW      (DW),
            .FIXED_PRIO (g)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Synchronous 512x12 memory per instance, read-old-data, with a backdoor preload port.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!mem_init_done) begin
                for (int a = 0; a < 512; a++) mem[d][a] <= '0;
            end else if (pre_en) begin
                mem[d][pre_addr] <= pre_dat;
            end else begin
                mem_rdata_arr[d] <= mem[d][o_mem_addr[d]];
                if (o_mem_wr[d]) mem[d][o_mem_addr[d]] <= o_mem_wdata[d];
            end
        end
        mem_init_done <= 1'b1;
    end

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [DW-1:0] model_mem [2][512];
    bit            m_pend  [2];
    int            m_gcyc  [2];
    logic          m_port  [2];
    logic          m_owner [2];
    logic          m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    int            cyc;
    bit            elig;
    logic          e_cack, e_lack, e_mwr, e_owner;
    logic [DW-1:0] e_crd, e_lrd, e_mwd, rd;
    logic [AW-1:0] e_maddr;

    // Winner of a grant opportunity, straight from the arbitration rules.
    function automatic logic pick(input int fp, input logic c, input logic l, input logic own, input logic lock);
        if (c && !l) return PORT_CPU;
        if (l && !c) return PORT_LD;
        if (lock && own == PORT_LD) return PORT_LD;
        if (fp != 0) return PORT_LD;
        return ~own;
    endfunction

    // Each access occupies three cycles from its grant: access at +1, ack at +2, free again at +3.
    initial begin
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 512; a++) model_mem[d][a] = '0;
            m_pend[d]  = 1'b0;
            m_owner[d] = PORT_LD;
            m_gcyc[d]  = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                e_cack = 1'b0; e_lack = 1'b0; e_crd = '0; e_lrd = '0;
                e_maddr = '1; e_mwr = 1'b0; e_mwd = '0;
                elig = 1'b0;
                if (pre_en) model_mem[d][pre_addr] = pre_dat;
                if (rst) begin
                    m_pend[d]  = 1'b0;
                    m_owner[d] = PORT_LD;
                end else begin
                    elig = !m_pend[d];
                    if (m_pend[d] && cyc == m_gcyc[d] + 1) begin
                        e_maddr = m_addr[d];
                        e_mwr   = m_we[d];
                        e_mwd   = m_wdata[d];
                    end
                    if (m_pend[d] && cyc == m_gcyc[d] + 2) begin
                        rd = model_mem[d][m_addr[d]];
                        if (m_we[d]) model_mem[d][m_addr[d]] = m_wdata[d];
                        if (m_port[d] == PORT_LD) begin
                            e_lack = 1'b1; e_lrd = rd;
                        end else begin
                            e_cack = 1'b1; e_crd = rd;
                        end
                        m_pend[d] = 1'b0;
                    end
                end
                e_owner = m_owner[d];
                check("cyc_cpu_ack",   d, 32'(o_cpu_ack[d]),   32'(e_cack));
                check("cyc_cpu_rdata", d, 32'(o_cpu_rdata[d]), 32'(e_crd));
                check("cyc_ld_ack",    d, 32'(o_ld_ack[d]),    32'(e_lack));
                check("cyc_ld_rdata",  d, 32'(o_ld_rdata[d]),  32'(e_lrd));
                check("cyc_mem_addr",  d, 32'(o_mem_addr[d]),  32'(e_maddr));
                check("cyc_mem_wr",    d, 32'(o_mem_wr[d]),    32'(e_mwr));
                check("cyc_mem_wdata", d, 32'(o_mem_wdata[d]), 32'(e_mwd));
                check("cyc_owner",     d, 32'(o_owner[d]),     32'(e_owner));
                if (elig && (cpu_req || ld_req)) begin
                    m_port[d]  = pick(d, cpu_req, ld_req, m_owner[d], ld_lock);
                    m_owner[d] = m_port[d];
                    m_pend[d]  = 1'b1;
                    m_gcyc[d]  = cyc;
                    m_we[d]    = (m_port[d] == PORT_LD) ? ld_we    : cpu_we;
                    m_addr[d]  = (m_port[d] == PORT_LD) ? ld_addr  : cpu_addr;
                    m_wdata[d] = (m_port[d] == PORT_LD) ? ld_wdata : cpu_wdata;
                end
            end
            cyc++;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_acks(input string nm, input int d, input logic c, input logic l);
        check({nm, "_cpu_ack"}, d, 32'(o_cpu_ack[d]), 32'(c));
        check({nm, "_ld_ack"},  d, 32'(o_ld_ack[d]),  32'(l));
    endtask

    int wr_cnt [2];

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_lock = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_dat = '0;

        step();
        for (int d = 0; d < 2; d++) begin
            chk_acks("rst", d, 1'b0, 1'b0);
            check("rst_mem_wr",   d, 32'(o_mem_wr[d]),   32'h0);
            check("rst_mem_addr", d, 32'(o_mem_addr[d]), 32'h1FF);
            check("rst_owner",    d, 32'(o_owner[d]),    32'h1);
        end
        pre_en = 1'b1; pre_addr = 9'o005; pre_dat = 12'o1234;
        step();
        pre_en = 1'b0;
        step();
        rst = 1'b0;

        // CPU read of a preloaded word: ack two cycles after the request.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'o005;
        step();
        for (int d = 0; d < 2; d++) begin
            chk_acks("t1_c1", d, 1'b0, 1'b0);
            check("t1_mem_addr", d, 32'(o_mem_addr[d]), 32'(9'o005));
        end
        step();
        for (int d = 0; d < 2; d++) begin
            chk_acks("t1_c2", d, 1'b1, 1'b0);
            check("t1_cpu_rdata", d, 32'(o_cpu_rdata[d]), 32'(12'o1234));
            check("t1_owner",     d, 32'(o_owner[d]),     32'h0);
        end
        cpu_req = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            chk_acks("t1_c3", d, 1'b0, 1'b0);
            check("t1_rdata_idle", d, 32'(o_cpu_rdata[d]), 32'h0);
        end

        // Loader write, then CPU reads it back; exactly one write strobe.
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'o100; ld_wdata = 12'o7000;
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        step();
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] += int'(o_mem_wr[d]);
            check("t2_mem_wr",    d, 32'(o_mem_wr[d]),    32'h1);
            check("t2_mem_addr",  d, 32'(o_mem_addr[d]),  32'(9'o100));
            check("t2_mem_wdata", d, 32'(o_mem_wdata[d]), 32'(12'o7000));
        end
        step();
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] += int'(o_mem_wr[d]);
            chk_acks("t2_ld", d, 1'b0, 1'b1);
        end
        ld_req = 1'b0; ld_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'o100;
        for (int k = 0; k < 3; k++) begin
            step();
            for (int d = 0; d < 2; d++) wr_cnt[d] += int'(o_mem_wr[d]);
        end
        for (int d = 0; d < 2; d++) begin
            chk_acks("t2_cpu", d, 1'b1, 1'b0);
            check("t2_cpu_rdata", d, 32'(o_cpu_rdata[d]), 32'(12'o7000));
            check("t2_wr_count",  d, 32'(wr_cnt[d]),      32'h1);
            check("t2_mem_word",  d, 32'(mem[d][9'o100]), 32'(12'o7000));
        end
        cpu_req = 1'b0;
        step();

        // Persistent simultaneous requests from reset; loader drops req in its 4th ack cycle.
        rst = 1'b1;
        step();
        for (int d = 0; d < 2; d++) check("t3_rst_owner", d, 32'(o_owner[d]), 32'h1);
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'o005;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 9'o100;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk_acks("t3_rr",    0, (k == 2 || k == 8 || k == 14), (k == 5 || k == 11));
            chk_acks("t4_fixed", 1, (k == 14), (k == 2 || k == 5 || k == 8 || k == 11));
            if (k == 11) ld_req = 1'b0;
        end
        cpu_req = 1'b0;

        // Loader lock: loader keeps winning ties while it owns; after release the CPU gets the next tie.
        step();
        cpu_req = 1'b1; ld_req = 1'b1; ld_lock = 1'b1;
        for (int k = 16; k <= 32; k++) begin
            step();
            chk_acks("t5_rr", 0, (k == 32),
                     (k == 17 || k == 20 || k == 23 || k == 26 || k == 29));
            chk_acks("t5_fixed", 1, 1'b0,
                     (k == 17 || k == 20 || k == 23 || k == 26 || k == 29 || k == 32));
            if (k == 29) ld_lock = 1'b0;
        end
        cpu_req = 1'b0; ld_req = 1'b0;

        // Reset lands during the access cycle of a CPU write: strobe dies at once, no ack, no write.
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'o010; cpu_wdata = 12'o0777;
        step();
        for (int d = 0; d < 2; d++) check("t6_acc_wr", d, 32'(o_mem_wr[d]), 32'h1);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("t6_wr_async",   d, 32'(o_mem_wr[d]),   32'h0);
            check("t6_addr_async", d, 32'(o_mem_addr[d]), 32'h1FF);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        for (int d = 0; d < 2; d++) chk_acks("t6_in_rst", d, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("t6_mem_kept", d, 32'(mem[d][9'o010]), 32'h0);
            check("t6_owner",    d, 32'(o_owner[d]),     32'h1);
        end
        cpu_req = 1'b1; cpu_addr = 9'o010;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk_acks("t6_after", d, 1'b1, 1'b0);
            check("t6_after_rdata", d, 32'(o_cpu_rdata[d]), 32'h0);
        end
        cpu_req = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
